// File: rtl/hc595_frame_ctrl.sv
`default_nettype none
// ============================================================================
// hc595_frame_ctrl : serialises {seg,sel} frames into two cascaded 74HC595s
// Optional skip of repeated frames: HC595_DEDUP_EN          Revision: 1.0
// ============================================================================
module hc595_frame_ctrl #(
   parameter logic [7:0] CLK_DIV = 8'd2,
   parameter int         FRAME_W = 14
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] seg_in,
   input  logic [5:0] sel_in,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       ds,
   output logic       shcp,
   output logic       stcp,
   output logic       oe_n,
   output logic       busy,
   output logic       frame_done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_LATCH = 2'd2;

   localparam logic [7:0] DIV_LAST = CLK_DIV - 8'd1;
   localparam logic [3:0] BIT_LAST = 4'(FRAME_W - 1);

   logic [1:0]         state_q, state_d;
   logic [7:0]         div_cnt_q, div_cnt_d;
   logic [3:0]         bit_cnt_q, bit_cnt_d;
   logic [FRAME_W-1:0] sr_q, sr_d;
   logic               ds_q, ds_d;
   logic               shcp_q, shcp_d;
   logic               stcp_q, stcp_d;
   logic               oe_n_q, oe_n_d;
   logic               in_ready_q, in_ready_d;
   logic               busy_q, busy_d;
   logic               frame_done_q, frame_done_d;

   logic [FRAME_W-1:0] w_frame;
   logic               w_accept;
   logic               w_skip;

   assign w_frame  = {seg_in, sel_in};
   assign w_accept = in_valid && in_ready_q;

`ifdef HC595_DEDUP_EN
   logic [FRAME_W-1:0] last_q, last_d;
   logic               last_valid_q, last_valid_d;

   assign w_skip = last_valid_q && (w_frame == last_q);
`else
   assign w_skip = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      div_cnt_d    = div_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      sr_d         = sr_q;
      ds_d         = ds_q;
      shcp_d       = shcp_q;
      stcp_d       = stcp_q;
      oe_n_d       = oe_n_q;
      in_ready_d   = in_ready_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
`ifdef HC595_DEDUP_EN
      last_d       = last_q;
      last_valid_d = last_valid_q;
`endif

      case (state_q)
         ST_IDLE: begin
            in_ready_d = 1'b1;
            busy_d     = 1'b0;
            shcp_d     = 1'b0;
            stcp_d     = 1'b0;
            if (w_accept && w_skip) begin
               frame_done_d = 1'b1;
            end else if (w_accept) begin
               state_d    = ST_SHIFT;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
               div_cnt_d  = 8'd0;
               bit_cnt_d  = 4'd0;
               ds_d       = w_frame[FRAME_W-1];
               sr_d       = w_frame << 1;
`ifdef HC595_DEDUP_EN
               last_d     = w_frame;
`endif
            end
         end

         ST_SHIFT: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = 8'd0;
               if (!shcp_q) begin
                  shcp_d = 1'b1;
               end else if (bit_cnt_q == BIT_LAST) begin
                  // stcp rises on the same edge shcp falls, never while shcp is high
                  state_d = ST_LATCH;
                  shcp_d  = 1'b0;
                  stcp_d  = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  shcp_d    = 1'b0;
                  ds_d      = sr_q[FRAME_W-1];
                  sr_d      = sr_q << 1;
               end
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end

         ST_LATCH: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d    = 8'd0;
               state_d      = ST_IDLE;
               stcp_d       = 1'b0;
               frame_done_d = 1'b1;
               oe_n_d       = 1'b0;
               in_ready_d   = 1'b1;
               busy_d       = 1'b0;
`ifdef HC595_DEDUP_EN
               last_valid_d = 1'b1;
`endif
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end

         default: begin
            state_d    = ST_IDLE;
            shcp_d     = 1'b0;
            stcp_d     = 1'b0;
            busy_d     = 1'b0;
            in_ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         div_cnt_q    <= 8'd0;
         bit_cnt_q    <= 4'd0;
         sr_q         <= '0;
         ds_q         <= 1'b0;
         shcp_q       <= 1'b0;
         stcp_q       <= 1'b0;
         oe_n_q       <= 1'b1;
         in_ready_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef HC595_DEDUP_EN
         last_q       <= '0;
         last_valid_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         div_cnt_q    <= div_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         sr_q         <= sr_d;
         ds_q         <= ds_d;
         shcp_q       <= shcp_d;
         stcp_q       <= stcp_d;
         oe_n_q       <= oe_n_d;
         in_ready_q   <= in_ready_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
`ifdef HC595_DEDUP_EN
         last_q       <= last_d;
         last_valid_q <= last_valid_d;
`endif
      end
   end

   assign in_ready   = in_ready_q;
   assign ds         = ds_q;
   assign shcp       = shcp_q;
   assign stcp       = stcp_q;
   assign oe_n       = oe_n_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_hc595_frame_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hc595_frame_ctrl : directed + randomized checks of the 595 frame sequencer
// Revision: 1.0
// ============================================================================
module tb_hc595_frame_ctrl;

   localparam int D = 2;
   localparam int FRAME_CYC = 29 * D + 1;

   logic       clk;
   logic       rst_n;
   logic [7:0] seg_in;
   logic [5:0] sel_in;
   logic       in_valid;
   logic       in_ready;
   logic       ds;
   logic       shcp;
   logic       stcp;
   logic       oe_n;
   logic       busy;
   logic       frame_done;

   int   checks;
   int   errors;
   logic oe_ref;

   hc595_frame_ctrl #(.CLK_DIV(8'(D))) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seg_in     (seg_in),
      .sel_in     (sel_in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ds         (ds),
      .shcp       (shcp),
      .stcp       (stcp),
      .oe_n       (oe_n),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Vector order: {ds, shcp, stcp, oe_n, in_ready, busy, frame_done}
   function automatic logic [6:0] obs_vec();
      return {ds, shcp, stcp, oe_n, in_ready, busy, frame_done};
   endfunction

   task automatic chk(input string tag, input logic [6:0] obs,
                      input logic [6:0] exp, input logic [6:0] mask);
      checks++;
      assert ((obs & mask) === (exp & mask)) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs & mask, exp & mask);
      end
   endtask

   // Expected waveform derived from the timing rules: cycle j after the accept edge.
   // mode 0: in_valid low; 1: in_valid held high with random data; 2: random in_valid/data
   task automatic run_frame(input logic [13:0] f, input int ncyc, input int mode);
      for (int j = 1; j <= ncyc; j++) begin
         int         t;
         int         bitn;
         logic [6:0] e;
         logic [6:0] m;
         @(negedge clk);
         t = j - 1;
         if (t < 28 * D) begin
            bitn = t / (2 * D);
            e = {f[13 - bitn], ((t % (2 * D)) >= D), 1'b0, oe_ref, 1'b0, 1'b1, 1'b0};
            m = 7'h7F;
         end else if (t < 29 * D) begin
            e = {1'b0, 1'b0, 1'b1, oe_ref, 1'b0, 1'b1, 1'b0};
            m = 7'h3F;
         end else begin
            oe_ref = 1'b0;
            e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
            m = 7'h3F;
         end
         chk($sformatf("frame_%h_cyc%0d", f, j), obs_vec(), e, m);
         if (mode == 0) begin
            in_valid = 1'b0;
         end else begin
            seg_in   = 8'($urandom);
            sel_in   = 6'($urandom);
            in_valid = (mode == 1) ? 1'b1 : 1'($urandom);
         end
      end
   endtask

   task automatic present(input logic [13:0] f);
      {seg_in, sel_in} = f;
      in_valid = 1'b1;
   endtask

   function automatic logic [13:0] rand_frame();
      logic [5:0] s;
      s = 6'd1 << $urandom_range(0, 5);
      return {8'($urandom), s};
   endfunction

   task automatic idle_check(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk(tag, obs_vec(), {1'b0, 1'b0, 1'b0, oe_ref, 1'b1, 1'b0, 1'b0}, 7'h3F);
      end
   endtask

   initial begin
      logic [13:0] fa;
      logic [13:0] fb;
      logic [13:0] fr;
      checks   = 0;
      errors   = 0;
      oe_ref   = 1'b1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      seg_in   = 8'h00;
      sel_in   = 6'h00;

      repeat (3) @(negedge clk);
      chk("reset_values", obs_vec(), 7'b0001000, 7'h7F);
      // reset must win over a simultaneous in_valid
      present(rand_frame());
      @(negedge clk);
      chk("reset_beats_valid", obs_vec(), 7'b0001000, 7'h7F);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("ready_after_release", obs_vec(), 7'b0001100, 7'h7F);
      idle_check("idle_after_reset", 8);

      // directed frame from the board bring-up pattern
      present({8'hC0, 6'b000001});
      run_frame({8'hC0, 6'b000001}, FRAME_CYC, 0);
      idle_check("idle_after_first", 3);

      // back-to-back with in_valid held high, alternating frames
      fa = rand_frame();
      fb = rand_frame();
      if (fb == fa) fb = fa ^ 14'h2A81;
      present(fa);
      run_frame(fa, FRAME_CYC, 1);
      present(fb);
      run_frame(fb, FRAME_CYC, 1);
      present(fa);
      run_frame(fa, FRAME_CYC, 1);
      in_valid = 1'b0;
      idle_check("idle_after_b2b", 2);

      // random frames with random idle gaps and noisy inputs while busy
      for (int n = 0; n < 4; n++) begin
         fr = rand_frame();
         present(fr);
         run_frame(fr, FRAME_CYC, 2);
         in_valid = 1'b0;
         idle_check("idle_gap", $urandom_range(1, 3));
      end

      // reset in the middle of bit 6
      fr = rand_frame();
      present(fr);
      run_frame(fr, 6 * 2 * D + 1, 0);
      rst_n = 1'b0;
      @(negedge clk);
      oe_ref = 1'b1;
      chk("midframe_reset", obs_vec(), 7'b0001000, 7'h7F);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_midreset", obs_vec(), 7'b0001100, 7'h7F);
      fr = rand_frame();
      present(fr);
      run_frame(fr, FRAME_CYC, 0);
      idle_check("idle_final", 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hc595_frame_ctrl.md
# hc595_frame_ctrl

Serial sequencer between the digit scanner and the two cascaded 74HC595 shift registers on the display board. Accepts one parallel frame (8-bit segment pattern plus 6-bit digit select) per valid/ready handshake and clocks it out on ds/shcp, MSB first. It then pulses stcp to latch all 14 outputs at once and reports completion. The output-enable line stays blanked until the first complete frame has been latched.

## Interface
- CLK_DIV, 8'd2: system clocks per shcp half-period; legal range 1..255.
- FRAME_W, 14: frame width in bits; fixed by board wiring and not overridden.

- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset; synchronous, active-low (sampled on rising clk)
- seg_in  input  8  segment pattern, active-low segments, bit 7 = dp
- sel_in  input  6  digit select, one-hot
- in_valid  input  1  frame present on seg_in/sel_in
- in_ready  output  1  block idle and able to accept a frame
- ds  output  1  serial data to the first 595
- shcp  output  1  shift clock
- stcp  output  1  storage (latch) clock
- oe_n  output  1  595 output enable, active-low
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse when a frame has been latched or retired

## Operation
- Frame word is {seg_in, sel_in}. Bit 13 (seg_in[7]) is shifted first, and bit 0 (sel_in[0]) is shifted last.
- Accept occurs on any clk edge where in_valid && in_ready. The frame is captured into an internal register at that edge. seg_in and sel_in are don't-care afterwards.
- FSM has three states: IDLE, SHIFT, LATCH.
  - IDLE: in_ready=1, busy=0, shcp=0, stcp=0. On accept, go to SHIFT with bit_cnt=0 and div_cnt=0.
  - SHIFT: each bit occupies 2*CLK_DIV cycles. ds carries the current bit for the whole bit period. shcp is 0 for the first CLK_DIV cycles and 1 for the second CLK_DIV cycles. The shift register advances on the shcp falling edge. After the high phase of bit 13, go to LATCH.
  - LATCH: shcp=0 and stcp=1 for CLK_DIV cycles. Then go to IDLE.
- frame_done pulses high in the first IDLE cycle after LATCH.
- oe_n is cleared to 0 in that same cycle and stays 0 until reset.
- in_ready and busy are registered, and are mutually exclusive outside reset.
- in_valid is ignored while not in IDLE; no queuing.
- div_cnt is 8 bits and counts 0..CLK_DIV-1. bit_cnt is 4 bits and counts 0..13; it does not wrap past 13.

## Timing
- All outputs are registered. Reset values: ds=0, shcp=0, stcp=0, oe_n=1, in_ready=0, busy=0, frame_done=0.
- in_ready rises in the first cycle after rst_n is sampled high.
- Accept at edge k gives the following sequence:
  - busy=1 and in_ready=0 from cycle k+1.
  - First shcp rising edge at cycle k+1+CLK_DIV.
  - stcp high during cycles k+1+28*CLK_DIV .. k+29*CLK_DIV.
  - frame_done=1 and in_ready=1 at cycle k+1+29*CLK_DIV. With CLK_DIV=2, this is k+59.
- A new frame can be accepted in the same cycle that frame_done is high, so back-to-back throughput is one frame per 29*CLK_DIV+1 cycles.
- ds never changes while shcp=1. stcp never rises while shcp=1.
- Reset asserted mid-frame: on the next edge all outputs take their reset values and the partial frame is discarded. oe_n stays 1 until a full frame completes.
- rst_n low in the same cycle as in_valid: reset wins and nothing is accepted.

## Configuration
- HC595_DEDUP_EN defined:
  - The block keeps the last latched frame and a last_valid flag; last_valid is cleared by reset.
  - If an accepted frame equals the stored frame and last_valid=1, shifting is skipped. FSM goes IDLE→IDLE, frame_done pulses at k+1, and in_ready stays 1.
  - ds, shcp and stcp do not toggle for a skipped frame.
- HC595_DEDUP_EN undefined: every accepted frame is shifted and latched in full. No comparison logic is present.

## Test plan
- Reset release, CLK_DIV=2, with no in_valid → all outputs hold their reset values. in_ready=1 from the second cycle; oe_n stays 1 indefinitely.
- Accept seg_in=8'hC0, sel_in=6'b000001 at edge k → 14 shcp rising edges. ds sampled at those edges equals 1,1,0,0,0,0,0,0,0,0,0,0,0,1. stcp is high during cycles k+57..k+58. frame_done and oe_n=0 occur at k+59.
- in_valid held high continuously with alternating frames → frames are accepted at k, k+59, k+118. No in_valid pulse is lost or double-accepted, and in_valid during busy is ignored.
- rst_n pulled low at bit 6 of a frame → next cycle: ds=shcp=stcp=0, oe_n=1, busy=0. A fresh frame after release completes normally.
- CLK_DIV=1 → shcp period of 2 cycles, frame_done at k+30. CLK_DIV=255 → frame_done at k+7396.
- HC595_DEDUP_EN defined, same frame sent twice → first frame takes the full 59 cycles. Second gives frame_done at k+1 with no shcp/stcp activity. Frame sent immediately after reset is always shifted.
